// File: rtl/boss_pkg.sv
// rtl/boss_pkg.sv - shared types and constants for the boss life controller
package boss_pkg;

    localparam int HEALTH_W = 4;
    localparam int TMR_W    = 24;

    localparam int unsigned DEF_INVULN_CYC  = 375000;
    localparam int unsigned DEF_BOOM_CYC    = 32'h00FF_FFFF;
    localparam int unsigned DEF_RESPAWN_CYC = 375000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACTIVE  = 3'd1,
        ST_INVULN  = 3'd2,
        ST_BOOM    = 3'd3,
        ST_RESPAWN = 3'd4
    } boss_state_e;

endpackage

// File: rtl/boss_life_ctrl_if.sv
// rtl/boss_life_ctrl_if.sv - hit handshake and status bundle of the boss life controller
interface boss_life_ctrl_if #(
    parameter int NUM_BUL = 4
);
    import boss_pkg::*;

    logic                start;
    logic [NUM_BUL-1:0]  hit_req;
    logic [NUM_BUL-1:0]  hit_ack;
    logic [HEALTH_W-1:0] health;
    logic                boss_en;
    logic                boom;
    logic                revive;
    logic [2:0]          state;

    modport master (
        output start, hit_req,
        input  hit_ack, health, boss_en, boom, revive, state
    );

    modport slave (
        input  start, hit_req,
        output hit_ack, health, boss_en, boom, revive, state
    );

endinterface

// File: rtl/boss_rr_arb.sv
// rtl/boss_rr_arb.sv - round-robin hit arbiter; never grants one slot on back-to-back cycles
module boss_rr_arb #(
    parameter int NUM_BUL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BUL-1:0] req,
    input  logic               en,
    output logic [NUM_BUL-1:0] gnt,
    output logic               gnt_vld
);
    localparam int PTR_W = (NUM_BUL > 1) ? $clog2(NUM_BUL) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_BUL-1:0] last_q, last_d;
    logic [NUM_BUL-1:0] elig;
    logic [PTR_W-1:0]   gidx;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gidx    = '0;
        ptr_d   = ptr_q;
        // last cycle's winner is masked so its requester has time to drop the request
        elig    = en ? (req & ~last_q) : '0;
        for (int i = 0; i < NUM_BUL; i++) begin
            if (!gnt_vld && elig[i] && (PTR_W'(i) >= ptr_q)) begin
                gnt[i]  = 1'b1;
                gnt_vld = 1'b1;
                gidx    = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_BUL; i++) begin
            if (!gnt_vld && elig[i] && (PTR_W'(i) < ptr_q)) begin
                gnt[i]  = 1'b1;
                gnt_vld = 1'b1;
                gidx    = PTR_W'(i);
            end
        end
        if (gnt_vld) begin
            ptr_d = (gidx == PTR_W'(NUM_BUL - 1)) ? '0 : gidx + 1'b1;
        end
        last_d = gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            last_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/boss_life_ctrl.sv
// rtl/boss_life_ctrl.sv - boss health/life FSM with round-robin bullet-hit arbitration
// Define BOSS_INVULN_EN to enable the timed INVULN state after a non-lethal hit.
module boss_life_ctrl
    import boss_pkg::*;
#(
    parameter int                  NUM_BUL     = 4,
    parameter logic [HEALTH_W-1:0] HEALTH_MAX  = 4'd8,
    parameter int unsigned         INVULN_CYC  = DEF_INVULN_CYC,
    parameter int unsigned         BOOM_CYC    = DEF_BOOM_CYC,
    parameter int unsigned         RESPAWN_CYC = DEF_RESPAWN_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    boss_life_ctrl_if.slave bus
);
    localparam logic [TMR_W-1:0] INVULN_LD  = TMR_W'(INVULN_CYC - 1);
    localparam logic [TMR_W-1:0] BOOM_LD    = TMR_W'(BOOM_CYC - 1);
    localparam logic [TMR_W-1:0] RESPAWN_LD = TMR_W'(RESPAWN_CYC - 1);

    boss_state_e         state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                boss_en_q, boss_en_d;
    logic                boom_q, boom_d;
    logic                revive_q, revive_d;
    logic [NUM_BUL-1:0]  ack_q, ack_d;
    logic [NUM_BUL-1:0]  gnt;
    logic                gnt_vld;
    logic                arb_en;

`ifdef BOSS_INVULN_EN
    assign arb_en = (state_q == ST_ACTIVE) || (state_q == ST_INVULN);
`else
    logic unused_invuln;
    assign unused_invuln = ^INVULN_LD;
    assign arb_en = (state_q == ST_ACTIVE);
`endif

    boss_rr_arb #(
        .NUM_BUL (NUM_BUL)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.hit_req),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        tmr_d    = tmr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ACTIVE;
                    health_d = HEALTH_MAX;
                end
            end
            ST_ACTIVE: begin
                if (gnt_vld) begin
                    if (health_q <= HEALTH_W'(1)) begin
                        health_d = '0;
                        state_d  = ST_BOOM;
                        tmr_d    = BOOM_LD;
                    end else begin
                        health_d = health_q - 1'b1;
`ifdef BOSS_INVULN_EN
                        state_d  = ST_INVULN;
                        tmr_d    = INVULN_LD;
`endif
                    end
                end
            end
`ifdef BOSS_INVULN_EN
            ST_INVULN: begin
                if (tmr_q == '0) state_d = ST_ACTIVE;
                else             tmr_d   = tmr_q - 1'b1;
            end
`endif
            ST_BOOM: begin
                if (tmr_q == '0) begin
                    state_d  = ST_RESPAWN;
                    health_d = HEALTH_MAX;
                    tmr_d    = RESPAWN_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (tmr_q == '0) state_d = bus.start ? ST_ACTIVE : ST_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // status flags are decoded from the next state so they flip on the same edge
        boss_en_d = (state_d == ST_ACTIVE) || (state_d == ST_INVULN) || (state_d == ST_RESPAWN);
        boom_d    = (state_d == ST_BOOM);
        revive_d  = (state_d == ST_RESPAWN);
        ack_d     = gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            health_q  <= '0;
            tmr_q     <= '0;
            boss_en_q <= 1'b0;
            boom_q    <= 1'b0;
            revive_q  <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            health_q  <= health_d;
            tmr_q     <= tmr_d;
            boss_en_q <= boss_en_d;
            boom_q    <= boom_d;
            revive_q  <= revive_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.health  = health_q;
    assign bus.boss_en = boss_en_q;
    assign bus.boom    = boom_q;
    assign bus.revive  = revive_q;
    assign bus.hit_ack = ack_q;

endmodule

// File: tb/tb_boss_life_ctrl.sv
// tb/tb_boss_life_ctrl.sv - scoreboard bench for boss_life_ctrl against a behavioural model
module tb_boss_life_ctrl;

    localparam int          NB  = 4;
    localparam int unsigned CYC = 4;
`ifdef BOSS_INVULN_EN
    localparam bit INV_EN = 1'b1;
    localparam int HMAX   = 3;
`else
    localparam bit INV_EN = 1'b0;
    localparam int HMAX   = 5;
`endif

    localparam int S_IDLE = 0, S_ACTIVE = 1, S_INVULN = 2, S_BOOM = 3, S_RESPAWN = 4;

    typedef struct {
        int          st;
        int          h;
        bit          en;
        bit          bm;
        bit          rv;
        logic [NB-1:0] ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    boss_life_ctrl_if #(.NUM_BUL(NB)) bus();

    boss_life_ctrl #(
        .NUM_BUL     (NB),
        .HEALTH_MAX  (4'(HMAX)),
        .INVULN_CYC  (CYC),
        .BOOM_CYC    (CYC),
        .RESPAWN_CYC (CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model: dwell counted as cycles remaining, arbiter as "last winner" slot
    int m_state = S_IDLE, m_health = 0, m_left = 0, m_last = NB - 1, m_prev = -1;

    function automatic int pick(input logic [NB-1:0] req);
        int s;
        for (int k = 1; k <= NB; k++) begin
            s = (m_last + k) % NB;
            if (req[s] && s != m_prev) return s;
        end
        return -1;
    endfunction

    initial begin
        exp_t e;
        int   g;
        forever begin
            @(posedge clk);
            g = -1;
            if (!rst_n) begin
                m_state = S_IDLE; m_health = 0; m_left = 0; m_last = NB - 1; m_prev = -1;
            end else begin
                if (m_state == S_ACTIVE || (INV_EN && m_state == S_INVULN)) g = pick(bus.hit_req);
                m_prev = g;
                if (g >= 0) m_last = g;
                case (m_state)
                    S_IDLE: if (bus.start) begin m_state = S_ACTIVE; m_health = HMAX; end
                    S_ACTIVE: if (g >= 0) begin
                        if (m_health <= 1) begin m_health = 0; m_state = S_BOOM; m_left = CYC; end
                        else begin
                            m_health--;
                            if (INV_EN) begin m_state = S_INVULN; m_left = CYC; end
                        end
                    end
                    S_INVULN: begin m_left--; if (m_left == 0) m_state = S_ACTIVE; end
                    S_BOOM: begin
                        m_left--;
                        if (m_left == 0) begin m_state = S_RESPAWN; m_health = HMAX; m_left = CYC; end
                    end
                    S_RESPAWN: begin
                        m_left--;
                        if (m_left == 0) m_state = bus.start ? S_ACTIVE : S_IDLE;
                    end
                    default: m_state = S_IDLE;
                endcase
            end
            e.st  = m_state;
            e.h   = m_health;
            e.en  = (m_state == S_ACTIVE) || (m_state == S_INVULN) || (m_state == S_RESPAWN);
            e.bm  = (m_state == S_BOOM);
            e.rv  = (m_state == S_RESPAWN);
            e.ack = (g >= 0) ? (NB'(1) << g) : '0;
            sb_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.state !== 3'(e.st) || bus.health !== 4'(e.h) || bus.boss_en !== e.en ||
                    bus.boom !== e.bm || bus.revive !== e.rv || bus.hit_ack !== e.ack) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got st=%0d h=%0d en=%b boom=%b rev=%b ack=%b, want st=%0d h=%0d en=%b boom=%b rev=%b ack=%b",
                             $time, bus.state, bus.health, bus.boss_en, bus.boom, bus.revive, bus.hit_ack,
                             e.st, e.h, e.en, e.bm, e.rv, e.ack);
                end
            end
        end
    end

    // requesters withdraw a bullet as soon as they see its ack
    initial begin
        forever begin
            @(negedge clk);
            bus.hit_req = bus.hit_req & ~bus.hit_ack;
        end
    end

    task automatic check_zero(input string nm);
        checks++;
        if (bus.state !== 3'd0 || bus.health !== 4'd0 || bus.boss_en !== 1'b0 ||
            bus.boom !== 1'b0 || bus.revive !== 1'b0 || bus.hit_ack !== '0) begin
            errors++;
            $display("FAIL %s: got st=%0d h=%0d en=%b boom=%b rev=%b ack=%b, want all zero",
                     nm, bus.state, bus.health, bus.boss_en, bus.boom, bus.revive, bus.hit_ack);
        end
    endtask

    task automatic set_req(input logic [NB-1:0] r);
        @(negedge clk);
        #1 bus.hit_req = r;
    endtask

    task automatic kill(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 150 && !ok; c++) begin
            @(negedge clk);
            if (bus.boom === 1'b1) ok = 1'b1;
            else begin
                #1;
                if (bus.state === 3'd1 && bus.hit_req === '0) bus.hit_req = NB'(1) << $urandom_range(0, NB - 1);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: boom=%b after 150 cycles, want 1", nm, bus.boom);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.hit_req = '0;
        #1 check_zero("reset_state");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // spawn, then simultaneous hits
        #1 bus.start = 1'b1;
        repeat (3) @(negedge clk);
        set_req(4'b1111);
        repeat (12) @(negedge clk);
        set_req(4'b1011);
        repeat (14) @(negedge clk);

        // kill with a request blocked during BOOM, respawn into ACTIVE
        kill("kill_respawn");
        #1 bus.hit_req = 4'b0100;
        repeat (14) @(negedge clk);

        // kill with start low -> back to IDLE
        kill("kill_idle");
        #1 bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // reset pulsed mid-BOOM
        #1 bus.start = 1'b1;
        kill("kill_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.start   = 1'b0;
        bus.hit_req = '0;
        #1 check_zero("mid_boom_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) bus.hit_req = bus.hit_req | NB'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
            #1;
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1 check_zero("random_reset");
            end
        end

        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
